axis_csum_appender: RTL and testbench
=====================================

Name: axis_csum_appender

Overview:
- Downstream AXI-Stream byte stage that consumes the packet FIFO's output stream (data/valid/ready/last).
- Passes every payload byte through unchanged, then appends a 2-byte modulo-2^16 sum of the packet, big-endian.
- Moves tlast from the final payload byte to the final checksum byte.
- One-deep registered output slot gives full-throughput streaming with backpressure.

Parameters:
- SEED, 16'h0000, initial value of the running sum at the start of every packet.
- MAX_PKT_LEN, 2048, largest legal payload length in bytes. Longer packets raise len_err.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- s_tdata  input  8  payload byte from the FIFO.
- s_tvalid  input  1  upstream byte valid.
- s_tready  output  1  block accepts s_tdata this cycle.
- s_tlast  input  1  marks the last payload byte of a packet.
- m_tdata  output  8  output byte (payload or checksum).
- m_tvalid  output  1  output byte valid.
- m_tready  input  1  downstream ready.
- m_tlast  output  1  asserted on the low checksum byte only.
- len_err  output  1  sticky flag: a packet exceeded MAX_PKT_LEN.

Behaviour:
- Reset: reset_n is asynchronous and active-low; assertion clears state immediately, including mid-packet.
- Reset values: m_tdata=0, m_tvalid=0, m_tlast=0, len_err=0, sum=SEED, len=0, state=PASS.
- The partial packet in flight at reset is discarded, and no checksum is emitted for it.
- slot_free = !m_tvalid || m_tready.
- s_tready = (state==PASS) && slot_free. This is combinational and never depends on s_tvalid.
- Output registers may change only when slot_free. While m_tvalid && !m_tready, m_tdata and m_tlast hold stable.
- If slot_free and no new byte is loaded, m_tvalid goes to 0.
- PASS, on handshake (s_tvalid && s_tready):
  - m_tdata<=s_tdata, m_tvalid<=1, m_tlast<=0.
  - sum<=sum+s_tdata (16-bit, wraps modulo 2^16, byte zero-extended).
  - len<=len+1 (12-bit, saturates at 4095).
  - If len+1 > MAX_PKT_LEN, set len_err (cleared only by reset).
  - If s_tlast: state<=CSUM_HI. The sum register then holds the final sum, including the last byte.
- CSUM_HI, when slot_free: m_tdata<=sum[15:8], m_tvalid<=1, m_tlast<=0, state<=CSUM_LO.
- CSUM_LO, when slot_free: m_tdata<=sum[7:0], m_tvalid<=1, m_tlast<=1, sum<=SEED, len<=0, state<=PASS.
- Latency: first payload byte appears on m_* 1 cycle after its input handshake.
- Throughput: sustains 1 byte/cycle with m_tready=1. Each packet costs 2 extra cycles, during which s_tready=0.
- The next packet's first byte is accepted in the cycle after the low checksum byte is loaded.
- A single-byte packet (s_tvalid&&s_tlast on the first byte) is legal and yields 3 output bytes.
- Zero-length packets cannot occur.
- s_tlast is ignored unless qualified by a handshake.
- m_tready may toggle arbitrarily. No byte is dropped or duplicated.

Optional Feature:
- Macro: CSUM_PKT_STATS_EN.
- Defined:
  - Adds output pkt_count (16 bits, reset 0). It increments by 1 on the m_* handshake of each byte with m_tlast=1, and wraps 0xFFFF->0.
  - Adds output max_len (12 bits, reset 0). It holds the largest payload length seen, updated when entering CSUM_HI.
- Undefined: neither port nor its registers exist. All other behaviour is identical.

Test Plan:
- Basic packet: payload 0x01,0x02,0x03 (last on 0x03), m_tready=1 -> m_tdata 01,02,03,00,06 on consecutive cycles; m_tlast only on 06; s_tready low for 2 cycles after 03.
- Wrap-around: 258 bytes of 0xFF -> checksum bytes 0x00,0xFE. len_err stays 0 with MAX_PKT_LEN=2048; with MAX_PKT_LEN=256, len_err=1 after byte 257.
- Backpressure: 4-byte packet 0x10,0x20,0x30,0x40 with m_tready toggling 1,0,0,1,... -> output sequence 10,20,30,40,00,A0 intact; m_tdata stable while stalled.
- Back-to-back single-byte packets 0x7F then 0x80 -> 7F,00,7F(last),80,00,80(last); no input byte lost.
- Reset mid-packet: assert reset_n=0 after 2 of 5 bytes -> m_tvalid=0 immediately. Next packet 0x05 (last) -> 05,00,05 with the sum restarted from SEED.
- CSUM_PKT_STATS_EN defined: three packets of lengths 3,7,2 -> pkt_count=3, max_len=7.

Source files
------------

// File: rtl/axis_csum_appender.sv
// axis_csum_appender
// AXI-Stream byte stage that forwards every payload byte unchanged and then
// appends a big-endian 16-bit modulo-2^16 sum of the packet. tlast moves from
// the final payload byte to the low checksum byte. A single registered output
// slot gives full-rate streaming with backpressure.
//
// Optional build macro CSUM_PKT_STATS_EN adds the pkt_count and max_len
// statistics outputs. Without it neither port nor its registers exist.
module axis_csum_appender #(
  parameter logic [15:0] SEED        = 16'h0000,
  parameter int          MAX_PKT_LEN = 2048
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        len_err
`ifdef CSUM_PKT_STATS_EN
  ,
  output logic [15:0] pkt_count,
  output logic [11:0] max_len
`endif
);

  typedef enum logic [1:0] {
    PASS    = 2'd0,
    CSUM_HI = 2'd1,
    CSUM_LO = 2'd2
  } state_t;

  // Length limit widened by one bit so len+1 never wraps in the compare.
  localparam logic [12:0] LEN_LIMIT = 13'(MAX_PKT_LEN);

  state_t      state;
  logic [15:0] sum;
  logic [11:0] len;

  logic        slot_free;
  logic        take;
  logic [11:0] len_next;
  logic        len_over;
  logic [15:0] sum_next;

  // Running sum: 16-bit add of a zero-extended byte, wraps modulo 2^16.
  function automatic logic [15:0] add_byte(input logic [15:0] acc,
                                           input logic [7:0]  b);
    return acc + {8'h00, b};
  endfunction

  // Packet length counter saturates at its all-ones value instead of wrapping.
  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  // The output slot can take a new byte when empty or being drained this cycle.
  assign slot_free = !m_tvalid || m_tready;
  assign s_tready  = (state == PASS) && slot_free;
  assign take      = s_tvalid && s_tready;
  assign len_next  = sat_inc12(len);
  assign len_over  = ({1'b0, len} + 13'd1) > LEN_LIMIT;
  assign sum_next  = add_byte(sum, s_tdata);

  // Output slot, running sum/length and the pass/checksum sequencer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= PASS;
      sum      <= SEED;
      len      <= 12'd0;
      m_tdata  <= 8'h00;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      len_err  <= 1'b0;
    end else if (slot_free) begin
      m_tvalid <= 1'b0;
      case (state)
        PASS: begin
          if (take) begin
            m_tdata  <= s_tdata;
            m_tvalid <= 1'b1;
            m_tlast  <= 1'b0;
            sum      <= sum_next;
            len      <= len_next;
            if (len_over) begin
              len_err <= 1'b1;
            end
            if (s_tlast) begin
              state <= CSUM_HI;
            end
          end
        end
        CSUM_HI: begin
          m_tdata  <= sum[15:8];
          m_tvalid <= 1'b1;
          m_tlast  <= 1'b0;
          state    <= CSUM_LO;
        end
        CSUM_LO: begin
          m_tdata  <= sum[7:0];
          m_tvalid <= 1'b1;
          m_tlast  <= 1'b1;
          sum      <= SEED;
          len      <= 12'd0;
          state    <= PASS;
        end
        default: begin
          state <= PASS;
        end
      endcase
    end
  end

`ifdef CSUM_PKT_STATS_EN
  // Count packets as their final checksum byte leaves on the output handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= 16'd0;
    end else if (m_tvalid && m_tready && m_tlast) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end

  // Track the longest payload, sampled as the packet moves into CSUM_HI.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_len <= 12'd0;
    end else if (take && s_tlast && (len_next > max_len)) begin
      max_len <= len_next;
    end
  end
`endif

endmodule

// File: tb/tb_axis_csum_appender.sv
// Testbench for axis_csum_appender: directed packets plus randomized traffic
// and ready patterns, checked against a packet-level reference model.
module tb_axis_csum_appender;

  localparam int MAX_LEN = 256;
  localparam int TMO     = 3000;

  typedef logic [7:0] bq_t[$];

  logic        clk;
  logic        reset_n;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        len_err;
`ifdef CSUM_PKT_STATS_EN
  logic [15:0] pkt_count;
  logic [11:0] max_len;
`endif

  int compared   = 0;
  int mismatched = 0;

  int  rmode    = 0;   // 0: ready always, 1: random ready, 2: 1,0,0 pattern
  int  pat      = 0;
  bit  idle_en  = 0;
  bit  model_err = 0;

  logic [8:0] expq[$];
  logic [8:0] gotq[$];

  bit         stall_prev = 0;
  logic [8:0] stall_val  = '0;

  axis_csum_appender #(
    .SEED        (16'h0000),
    .MAX_PKT_LEN (MAX_LEN)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .len_err  (len_err)
`ifdef CSUM_PKT_STATS_EN
    ,
    .pkt_count (pkt_count),
    .max_len   (max_len)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output collector on the falling edge; also checks the slot holds while stalled.
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", {31'd0, m_tvalid}, 32'd1);
        check("stall_hold", {23'd0, m_tlast, m_tdata}, {23'd0, stall_val});
      end
      if (m_tvalid && m_tready) gotq.push_back({m_tlast, m_tdata});
      stall_prev = m_tvalid && !m_tready;
      stall_val  = {m_tlast, m_tdata};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    case (rmode)
      1: m_tready = ($urandom_range(0, 3) != 0);
      2: begin m_tready = (pat % 3 == 0); pat++; end
      default: m_tready = 1'b1;
    endcase
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int g;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    g = 0;
    while (!s_tready && g < TMO) begin
      step();
      g++;
    end
    if (g >= TMO) check("sready_timeout", {31'd0, s_tready}, 32'd1);
    step();
    s_tvalid = 1'b0;
    s_tlast  = 1'($urandom_range(0, 1));
    s_tdata  = 8'($urandom);
    if (idle_en && $urandom_range(0, 3) == 0) step();
  endtask

  // Reference model: payload bytes, then sum high/low with tlast on the low byte.
  task automatic send_pkt(input bq_t pk);
    int s;
    int plen;
    s = 0;
    plen = 0;
    foreach (pk[i]) begin
      send_byte(pk[i], i == pk.size() - 1);
      expq.push_back({1'b0, pk[i]});
      s = (s + int'(pk[i])) % 65536;
      plen++;
      if (plen > MAX_LEN) model_err = 1;
      check("len_err", {31'd0, len_err}, {31'd0, model_err});
    end
    expq.push_back({1'b0, 8'(s >> 8)});
    expq.push_back({1'b1, 8'(s)});
  endtask

  task automatic compare_out(input string tag);
    int g;
    int n;
    g = 0;
    s_tvalid = 1'b0;
    while (gotq.size() < expq.size() && g < TMO) begin
      step();
      g++;
    end
    step();
    step();
    check({tag, "_count"}, gotq.size(), expq.size());
    n = (gotq.size() < expq.size()) ? gotq.size() : expq.size();
    for (int i = 0; i < n; i++)
      check({tag, "_byte"}, {23'd0, gotq[i]}, {23'd0, expq[i]});
    gotq.delete();
    expq.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #7;
    reset_n = 1'b1;
    model_err = 0;
    gotq.delete();
    expq.delete();
    step();
  endtask

  initial begin
    bq_t q;
    reset_n  = 1'b0;
    s_tdata  = 8'h00;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    #12;

    // Reset state
    check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_tdata", {24'd0, m_tdata}, 32'd0);
    check("rst_tlast", {31'd0, m_tlast}, 32'd0);
    check("rst_len_err", {31'd0, len_err}, 32'd0);
    check("rst_s_tready", {31'd0, s_tready}, 32'd1);
    reset_n = 1'b1;
    step();

    // Basic packet 01,02,03 with exact timing of the checksum bytes
    rmode = 0; idle_en = 0;
    q = '{8'h01, 8'h02, 8'h03};
    send_pkt(q);
    check("basic_rdy0", {31'd0, s_tready}, 32'd0);
    check("basic_d3", {23'd0, m_tlast, m_tdata}, {23'd0, 9'h003});
    step();
    check("basic_rdy1", {31'd0, s_tready}, 32'd0);
    check("basic_hi", {23'd0, m_tlast, m_tdata}, {23'd0, 9'h000});
    step();
    check("basic_rdy2", {31'd0, s_tready}, 32'd1);
    check("basic_lo", {23'd0, m_tlast, m_tdata}, {23'd0, 9'h106});
    compare_out("basic");

    // Wrap-around: 258 x 0xFF, length error after byte 257
    q = {};
    for (int i = 0; i < 258; i++) q.push_back(8'hFF);
    send_pkt(q);
    compare_out("wrap");

    // Backpressure with ready pattern 1,0,0
    rmode = 2; pat = 0;
    q = '{8'h10, 8'h20, 8'h30, 8'h40};
    send_pkt(q);
    compare_out("bp");
    rmode = 0;

    // Back-to-back single-byte packets
    q = '{8'h7F};
    send_pkt(q);
    q = '{8'h80};
    send_pkt(q);
    compare_out("b2b");

    // Reset mid-packet: second byte in the slot is discarded
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    expq.push_back({1'b0, 8'h11});
    reset_n = 1'b0;
    #1;
    check("midrst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("midrst_len_err", {31'd0, len_err}, 32'd0);
    #5;
    reset_n = 1'b1;
    model_err = 0;
    step();
    compare_out("midrst_pre");
    q = '{8'h05};
    send_pkt(q);
    compare_out("midrst_post");

    // Randomized traffic with random ready and idle gaps
    rmode = 1; idle_en = 1;
    for (int p = 0; p < 25; p++) begin
      q = {};
      for (int i = 0; i < int'($urandom_range(1, 20)); i++) q.push_back(8'($urandom));
      send_pkt(q);
    end
    compare_out("rand");
    rmode = 0; idle_en = 0;

`ifdef CSUM_PKT_STATS_EN
    // Statistics: packets of length 3, 7, 2
    do_reset();
    q = {}; for (int i = 0; i < 3; i++) q.push_back(8'($urandom)); send_pkt(q);
    q = {}; for (int i = 0; i < 7; i++) q.push_back(8'($urandom)); send_pkt(q);
    q = {}; for (int i = 0; i < 2; i++) q.push_back(8'($urandom)); send_pkt(q);
    compare_out("stats");
    check("pkt_count", {16'd0, pkt_count}, 32'd3);
    check("max_len", {20'd0, max_len}, 32'd7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
